// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared widths, owner encodings and active-low grant levels for the bus arbiter
package bus_arbiter_pkg;
  localparam int BUS_OWNER_W = 2;
  localparam int BUS_ARB_HOLD_W = 8;
  typedef logic [BUS_OWNER_W-1:0] owner_t;
  localparam owner_t BUS_OWNER_MASTER_0 = 2'h0;
  localparam owner_t BUS_OWNER_MASTER_1 = 2'h1;
  localparam owner_t BUS_OWNER_MASTER_2 = 2'h2;
  localparam owner_t BUS_OWNER_MASTER_3 = 2'h3;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick: keeps a requesting owner, else picks the first requester from owner+1 round-robin
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  owner_t     owner,
  input  logic [3:0] req,
  output owner_t     next_owner,
  output logic       found
);
  always_comb begin
    next_owner = owner;
    found = req[owner];
    for (int i = 1; i < 4; i++) begin
      if (!found && req[owner + 2'(i)]) begin
        found = 1'b1;
        next_owner = owner + 2'(i);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter with registered owner; BUS_ARB_TIMEOUT_EN adds a MAX_HOLD limit
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         m0_req_,
  input  logic         m1_req_,
  input  logic         m2_req_,
  input  logic         m3_req_,
  output logic         m0_grnt_,
  output logic         m1_grnt_,
  output logic         m2_grnt_,
  output logic         m3_grnt_,
  output logic [BUS_OWNER_W-1:0] bus_owner
);
  owner_t owner_q, owner_d, pick_owner;
  logic [3:0] req, pick_req;
  logic found;
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end
  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
`ifdef BUS_ARB_TIMEOUT_EN
  logic [BUS_ARB_HOLD_W-1:0] hold_q, hold_d;
  logic compete, force_rot;
  always_comb begin
    compete = |(req & ~(4'b1 << owner_q));
    force_rot = compete && hold_q == BUS_ARB_HOLD_W'(MAX_HOLD - 1);
    // masking the owner's own request makes the search rotate past it
    pick_req = force_rot ? req & ~(4'b1 << owner_q) : req;
    hold_d = (!compete || owner_d != owner_q) ? '0 : (&hold_q ? hold_q : hold_q + 1'b1);
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) hold_q <= '0;
    else hold_q <= hold_d;
`else
  assign pick_req = req;
`endif
  bus_arb_rr_pick u_pick (.owner(owner_q), .req(pick_req), .next_owner(pick_owner), .found(found));
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) owner_q <= BUS_OWNER_MASTER_0;
    else owner_q <= owner_d;
  always_comb owner_d = found ? pick_owner : owner_q;
  always_comb begin
    m0_grnt_ = owner_q == BUS_OWNER_MASTER_0 ? ENABLE_ : DISABLE_;
    m1_grnt_ = owner_q == BUS_OWNER_MASTER_1 ? ENABLE_ : DISABLE_;
    m2_grnt_ = owner_q == BUS_OWNER_MASTER_2 ? ENABLE_ : DISABLE_;
    m3_grnt_ = owner_q == BUS_OWNER_MASTER_3 ? ENABLE_ : DISABLE_;
    bus_owner = owner_q;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a round-robin reference model
module tb_bus_arbiter;
  localparam int MAXH = 4;
  logic clk = 1'b0;
  logic reset_;
  logic m0_req_, m1_req_, m2_req_, m3_req_;
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] bus_owner;
  int checks = 0;
  int failures = 0;
  int mo = 0;
  int ms = 0;
  bus_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset_(reset_),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .bus_owner(bus_owner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    logic [3:0] g;
    g = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    chk({tag, "_grnt"}, int'(g), int'(~(4'b1 << mo) & 4'hF));
    chk({tag, "_owner"}, int'(bus_owner), mo);
  endtask
  // reference: one arbitration decision from the spoken rules, r is active-high requests
  task automatic mdl_step(input logic [3:0] r);
    bit comp;
    bit frc;
    int nxt;
    comp = 0;
    frc = 0;
    nxt = mo;
    for (int j = 0; j < 4; j++) if (j != mo && r[j]) comp = 1;
`ifdef BUS_ARB_TIMEOUT_EN
    frc = comp && ms == MAXH - 1;
`endif
    if (!r[mo] || frc)
      for (int k = 1; k < 4; k++)
        if (r[(mo + k) % 4]) begin
          nxt = (mo + k) % 4;
          break;
        end
    ms = (nxt != mo || !comp) ? 0 : (ms < 255 ? ms + 1 : ms);
    mo = nxt;
  endtask
  task automatic step(input string tag, input logic [3:0] r);
    @(negedge clk);
    chk_state(tag);
    {m3_req_, m2_req_, m1_req_, m0_req_} = ~r;
    if (reset_) mdl_step(r);
  endtask
  initial begin
    int owned;
    int seq[$];
    int cnt;
    logic [3:0] r;
    reset_ = 1'b0;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'hF;
    #1 chk_state("reset");
    @(negedge clk);
    @(negedge clk) reset_ = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 4'b0000);
    step("m2_req", 4'b0100);
    step("m2_grant", 4'b0100);
    chk("m2_owner", int'(bus_owner), 2);
    step("m2_release", 4'b0000);
    step("park0", 4'b0001);
    step("park0b", 4'b0000);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      r = 4'hF;
      if (cnt == 2) r[mo] = 1'b0;
      step("rr4", r);
      if (int'(bus_owner) != (seq.size() ? seq[$] : -1)) seq.push_back(int'(bus_owner));
      cnt = (cnt == 2) ? 0 : cnt + 1;
    end
    chk("rr_seq1", seq[1], 1);
    chk("rr_seq2", seq[2], 2);
    chk("rr_seq3", seq[3], 3);
    chk("rr_seq4", seq[4], 0);
    step("to3", 4'b1000);
    step("hold3", 4'b1101);
    step("rel3", 4'b0101);
    step("wrap", 4'b0101);
    chk("wrap_owner", int'(bus_owner), 0);
    step("to2a", 4'b0100);
    step("to2b", 4'b0100);
    step("to2c", 4'b0100);
    chk("pre_rst_owner", int'(bus_owner), 2);
    #2 reset_ = 1'b0;
    mo = 0;
    ms = 0;
    #1 chk_state("async_rst");
    step("in_rst", 4'b0100);
    @(negedge clk) reset_ = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'hF;
    step("post_rst", 4'b0000);
    step("to1", 4'b1010);
    owned = 0;
    for (int i = 0; i < 8; i++) begin
      step("hold1", 4'b1010);
      if (bus_owner == 2'd1) owned++;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    chk("hold_cycles", owned, MAXH);
`else
    chk("hold_cycles", owned, 8);
`endif
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'h0;
      step("rand", r);
    end
    step("final", 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
